// File: rtl/axi_writer_pkg.sv
// Shared types and helpers for the AXI burst writer.
package axi_writer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StAddr,
    StData,
    StResp,
    StFin
  } state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Beats in the next burst: whatever is left, capped at the burst length.
  function automatic logic [31:0] burst_beats(input logic [31:0] remaining,
                                              input logic [31:0] burst_len);
    return (remaining < burst_len) ? remaining : burst_len;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and flush.
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == FullCount);
  assign do_push = push & ~full;
  assign do_pop  = pop & (count_q != '0);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointers and count; flush behaves like a local reset.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/axi_burst_writer.sv
// Streams buffered words out as AXI INCR write bursts from a programmed base.
// Optional macro AXI_WRITER_ERRCHK_EN: non-OKAY bresp sets sticky err and aborts.
module axi_burst_writer
  import axi_writer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [31:0]           num_beats,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [7:0]            awlen,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           total_q, remaining_q, accepted_q, beat_q;
  logic                  err_q;
  logic [31:0]           cur_beats;
  logic                  last_beat, w_hs, b_hs, resp_err;
  logic                  fifo_push, fifo_pop, fifo_flush, fifo_full;
  logic [CntW-1:0]       fifo_count;
  logic [DATA_WIDTH-1:0] fifo_rdata;

`ifdef AXI_WRITER_ERRCHK_EN
  assign resp_err = (bresp != RESP_OKAY);
`else
  logic unused_bresp;
  assign unused_bresp = ^bresp;
  assign resp_err     = 1'b0;
`endif

  assign cur_beats  = burst_beats(remaining_q, 32'(BURST_LEN));
  assign last_beat  = (beat_q == cur_beats - 32'd1);
  assign w_hs       = (state_q == StData) & wready;
  assign b_hs       = (state_q == StResp) & bvalid;
  assign fifo_push  = s_valid & s_ready;
  assign fifo_pop   = w_hs;
  assign fifo_flush = b_hs & resp_err;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (fifo_flush),
    .push  (fifo_push),
    .wdata (s_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic; an errored response skips any remaining bursts.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = (num_beats == 32'd0) ? StFin : StFill;
      StFill: if (32'(fifo_count) >= cur_beats) state_d = StAddr;
      StAddr: if (awready) state_d = StData;
      StData: if (wready && last_beat) state_d = StResp;
      StResp: if (bvalid) state_d = (resp_err || remaining_q == cur_beats) ? StFin : StFill;
      StFin:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs; wdata is masked so it reads zero outside DATA.
  always_comb begin
    awvalid = (state_q == StAddr);
    wvalid  = (state_q == StData);
    wlast   = (state_q == StData) & last_beat;
    bready  = (state_q == StResp);
    busy    = (state_q != StIdle);
    done    = (state_q == StFin);
    awaddr  = addr_q;
    awlen   = (cur_beats == 32'd0) ? 8'd0 : 8'(cur_beats - 32'd1);
    wdata   = wvalid ? fifo_rdata : '0;
    err     = err_q;
    s_ready = busy & ~fifo_full & (accepted_q < total_q) & ~err_q;
  end

  // Transfer bookkeeping: address, beat counters and sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q      <= '0;
      total_q     <= '0;
      remaining_q <= '0;
      accepted_q  <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      if (state_q == StIdle && start) begin
        addr_q      <= base_addr;
        total_q     <= num_beats;
        remaining_q <= num_beats;
        accepted_q  <= '0;
        beat_q      <= '0;
        err_q       <= 1'b0;
      end
      if (fifo_push) accepted_q <= accepted_q + 32'd1;
      if (w_hs) beat_q <= last_beat ? 32'd0 : beat_q + 32'd1;
      if (b_hs) begin
        addr_q      <= addr_q + ADDR_WIDTH'(cur_beats);
        remaining_q <= remaining_q - cur_beats;
        if (resp_err) err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_writer.sv
// Directed bench for axi_burst_writer with a small AXI slave model.
module tb_axi_burst_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] num_beats = '0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic        wlast;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;
  logic        busy;
  logic        done;
  logic        err;

  axi_burst_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .num_beats (num_beats),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .awaddr    (awaddr),
    .awlen     (awlen),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wlast     (wlast),
    .wvalid    (wvalid),
    .wready    (wready),
    .bresp     (bresp),
    .bvalid    (bvalid),
    .bready    (bready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stream source and slave behaviour knobs.
  logic [31:0] src [64];
  int          src_n, src_idx;
  bit          gaps, stall_aw, stall_w, hold_w;
  int          err_burst;

  // Slave/monitor state.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] aw_log_addr [16];
  logic [7:0]  aw_log_len [16];
  logic [31:0] cur_aw, last_data;
  int          wbeat, aw_cnt, aw_any, w_cnt, wlast_cnt, b_cnt, pending_b;
  int          done_cnt, done_b_cnt, aw_unstable, w_unstable, w_early;
  bit          prev_aw_wait, prev_w_wait;
  logic [31:0] prev_awaddr, prev_wdata;
  logic [7:0]  prev_awlen;

  task automatic reset_tb_state();
    mem.delete();
    src_idx = 0; src_n = 0; gaps = 0; stall_aw = 0; stall_w = 0; hold_w = 0;
    err_burst = -1; cur_aw = '0; last_data = '0; wbeat = 0; aw_cnt = 0; aw_any = 0;
    w_cnt = 0; wlast_cnt = 0; b_cnt = 0; pending_b = 0; done_cnt = 0; done_b_cnt = -1;
    aw_unstable = 0; w_unstable = 0; w_early = 0; prev_aw_wait = 0; prev_w_wait = 0;
  endtask

  // One clock: observe handshakes at the falling edge, drive just after the rising edge.
  task automatic step();
    @(negedge clk);
    if (prev_aw_wait && (!awvalid || awaddr !== prev_awaddr || awlen !== prev_awlen))
      aw_unstable++;
    if (prev_w_wait && (!wvalid || wdata !== prev_wdata)) w_unstable++;
    prev_aw_wait = awvalid && !awready;
    prev_awaddr  = awaddr;
    prev_awlen   = awlen;
    prev_w_wait  = wvalid && !wready;
    prev_wdata   = wdata;
    if (awvalid) aw_any++;
    if (wvalid && aw_cnt <= wlast_cnt) w_early++;
    if (awvalid && awready) begin
      if (aw_cnt < 16) begin
        aw_log_addr[aw_cnt] = awaddr;
        aw_log_len[aw_cnt]  = awlen;
      end
      cur_aw = awaddr;
      wbeat  = 0;
      aw_cnt++;
    end
    if (wvalid && wready) begin
      mem[cur_aw + 32'(wbeat)] = wdata;
      wbeat++;
      w_cnt++;
      if (wlast) begin
        wlast_cnt++;
        last_data = wdata;
        pending_b++;
      end
    end
    if (bvalid && bready) begin
      b_cnt++;
      pending_b--;
    end
    if (s_valid && s_ready) src_idx++;
    if (done) begin
      done_cnt++;
      done_b_cnt = b_cnt;
    end
    @(posedge clk);
    #1;
    awready = stall_aw ? ($urandom_range(0, 1) == 1) : 1'b1;
    wready  = hold_w ? 1'b0 : (stall_w ? ($urandom_range(0, 2) != 0) : 1'b1);
    s_valid = (src_idx < src_n) && (!gaps || $urandom_range(0, 2) != 0);
    s_data  = src[src_idx % 64];
    bvalid  = (pending_b > 0);
    bresp   = (b_cnt == err_burst) ? 2'b10 : 2'b00;
  endtask

  task automatic pulse_start(input logic [31:0] b, input logic [31:0] n);
    start = 1'b1;
    base_addr = b;
    num_beats = n;
    step();
    start = 1'b0;
  endtask

  task automatic run_done(input int budget, output bit timeout);
    for (int i = 0; i < budget; i++) begin
      step();
      if (done_cnt != 0) break;
    end
    timeout = (done_cnt == 0);
    step();
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    reset_tb_state();
    repeat (3) step();
    checks++;
    if ({s_ready, awvalid, wvalid, wlast, bready, busy, done, err} !== 8'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000000",
               {s_ready, awvalid, wvalid, wlast, bready, busy, done, err});
    end
    checks++;
    if (awaddr !== 32'h0) begin errors++; $display("FAIL reset_awaddr: got %h expected 0", awaddr); end
    checks++;
    if (awlen !== 8'h0) begin errors++; $display("FAIL reset_awlen: got %h expected 0", awlen); end
    checks++;
    if (wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", wdata); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_burst();
    bit to;
    reset_tb_state();
    src[0] = 32'hA5A5_A5A5; src[1] = 32'h5A5A_5A5A; src[2] = 32'h1234_5678; src[3] = 32'h8765_4321;
    src_n = 4;
    pulse_start(32'h0, 32'd4);
    run_done(200, to);
    checks++;
    if (to) begin errors++; $display("FAIL single_timeout: done never seen"); end
    checks++;
    if (aw_cnt != 1 || aw_log_addr[0] !== 32'h0 || aw_log_len[0] !== 8'd3) begin
      errors++;
      $display("FAIL single_aw: got cnt %0d addr %h len %0d expected 1 0 3",
               aw_cnt, aw_log_addr[0], aw_log_len[0]);
    end
    checks++;
    if (last_data !== 32'h8765_4321 || wlast_cnt != 1) begin
      errors++;
      $display("FAIL single_wlast: got %h x%0d expected 87654321 x1", last_data, wlast_cnt);
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL single_done: got %0d expected 1", done_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (!mem.exists(32'(i)) || mem[32'(i)] !== src[i]) begin
        errors++;
        $display("FAIL single_mem[%0d]: got %h expected %h", i,
                 mem.exists(32'(i)) ? mem[32'(i)] : 32'hxxxx_xxxx, src[i]);
      end
    end
  endtask

  task automatic test_multi_burst();
    bit to;
    logic [31:0] exp_addr [3];
    logic [7:0]  exp_len [3];
    exp_addr[0] = 32'h100; exp_addr[1] = 32'h104; exp_addr[2] = 32'h108;
    exp_len[0] = 8'd3; exp_len[1] = 8'd3; exp_len[2] = 8'd1;
    reset_tb_state();
    for (int i = 0; i < 10; i++) src[i] = 32'h1000_0000 + 32'(i);
    src_n = 10;
    pulse_start(32'h100, 32'd10);
    run_done(400, to);
    checks++;
    if (to) begin errors++; $display("FAIL multi_timeout: done never seen"); end
    checks++;
    if (aw_cnt != 3) begin errors++; $display("FAIL multi_aw_cnt: got %0d expected 3", aw_cnt); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (aw_log_addr[i] !== exp_addr[i] || aw_log_len[i] !== exp_len[i]) begin
        errors++;
        $display("FAIL multi_aw[%0d]: got %h/%0d expected %h/%0d", i, aw_log_addr[i],
                 aw_log_len[i], exp_addr[i], exp_len[i]);
      end
    end
    checks++;
    if (b_cnt != 3 || done_b_cnt != 3 || done_cnt != 1) begin
      errors++;
      $display("FAIL multi_b_done: got b %0d at_done %0d done %0d expected 3 3 1",
               b_cnt, done_b_cnt, done_cnt);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (!mem.exists(32'h100 + 32'(i)) || mem[32'h100 + 32'(i)] !== src[i]) begin
        errors++;
        $display("FAIL multi_mem[%0d]: expected %h", i, src[i]);
      end
    end
  endtask

  task automatic test_stalls();
    bit to;
    logic [31:0] base;
    base = 32'hFFFF_FFFE;
    reset_tb_state();
    for (int i = 0; i < 13; i++) src[i] = 32'hC0DE_0000 + 32'(i * 7);
    src_n = 13; gaps = 1; stall_aw = 1; stall_w = 1;
    pulse_start(base, 32'd13);
    run_done(2000, to);
    checks++;
    if (to) begin errors++; $display("FAIL stall_timeout: done never seen"); end
    checks++;
    if (w_cnt != 13 || wlast_cnt != 4) begin
      errors++;
      $display("FAIL stall_beats: got %0d beats %0d last expected 13 4", w_cnt, wlast_cnt);
    end
    checks++;
    if (aw_log_addr[1] !== 32'h2 || aw_log_addr[3] !== 32'hA || aw_log_len[3] !== 8'd0) begin
      errors++;
      $display("FAIL stall_wrap: got %h %h len %0d expected 2 a 0",
               aw_log_addr[1], aw_log_addr[3], aw_log_len[3]);
    end
    checks++;
    if (aw_unstable != 0 || w_unstable != 0 || w_early != 0) begin
      errors++;
      $display("FAIL stall_stability: got aw %0d w %0d early %0d expected 0 0 0",
               aw_unstable, w_unstable, w_early);
    end
    for (int i = 0; i < 13; i++) begin
      checks++;
      if (!mem.exists(base + 32'(i)) || mem[base + 32'(i)] !== src[i]) begin
        errors++;
        $display("FAIL stall_mem[%0d]: expected %h", i, src[i]);
      end
    end
  endtask

  task automatic test_zero_beats();
    int lat;
    reset_tb_state();
    lat = 0;
    pulse_start(32'h40, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      if (done && lat == 0) lat = i;
      step();
    end
    checks++;
    if (lat < 1 || lat > 2) begin errors++; $display("FAIL zero_latency: got %0d expected 1..2", lat); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL zero_done_cnt: got %0d expected 1", done_cnt); end
    checks++;
    if (aw_any != 0) begin errors++; $display("FAIL zero_awvalid: got %0d expected 0", aw_any); end
  endtask

  task automatic test_reset_mid();
    bit to;
    bit reached;
    reset_tb_state();
    for (int i = 0; i < 8; i++) src[i] = 32'hDEAD_0000 + 32'(i);
    src_n = 8; hold_w = 1;
    pulse_start(32'h0, 32'd8);
    reached = 0;
    for (int i = 0; i < 50 && !reached; i++) begin
      step();
      reached = wvalid;
    end
    checks++;
    if (!reached) begin errors++; $display("FAIL rstmid_reach: wvalid got 0 expected 1"); end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({s_ready, awvalid, wvalid, wlast, bready, busy, done, err} !== 8'b0 ||
        awaddr !== 32'h0 || awlen !== 8'h0 || wdata !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_outputs: got %b %h %h %h expected all zero",
               {s_ready, awvalid, wvalid, wlast, bready, busy, done, err}, awaddr, awlen, wdata);
    end
    reset_tb_state();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) src[i] = 32'hBEEF_0000 + 32'(i);
    src_n = 4;
    pulse_start(32'h40, 32'd4);
    run_done(200, to);
    checks++;
    if (to || aw_cnt != 1 || aw_log_addr[0] !== 32'h40) begin
      errors++;
      $display("FAIL rstmid_restart: got timeout %0d aw %0d addr %h expected 0 1 40",
               to, aw_cnt, aw_log_addr[0]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (!mem.exists(32'h40 + 32'(i)) || mem[32'h40 + 32'(i)] !== src[i]) begin
        errors++;
        $display("FAIL rstmid_mem[%0d]: expected %h", i, src[i]);
      end
    end
  endtask

  task automatic test_error_resp();
    bit to;
    reset_tb_state();
    for (int i = 0; i < 12; i++) src[i] = 32'hE000_0000 + 32'(i);
    src_n = 12; err_burst = 0;
    pulse_start(32'h200, 32'd12);
    run_done(400, to);
    checks++;
    if (to || done_cnt != 1) begin
      errors++;
      $display("FAIL err_done: got timeout %0d done %0d expected 0 1", to, done_cnt);
    end
`ifdef AXI_WRITER_ERRCHK_EN
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_flag: got %b expected 1", err); end
    checks++;
    if (aw_cnt != 1 || aw_any != 1 || b_cnt != 1) begin
      errors++;
      $display("FAIL err_abort: got aw %0d cycles %0d b %0d expected 1 1 1", aw_cnt, aw_any, b_cnt);
    end
`else
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_flag: got %b expected 0", err); end
    checks++;
    if (aw_cnt != 3 || b_cnt != 3 || w_cnt != 12) begin
      errors++;
      $display("FAIL err_bursts: got aw %0d b %0d w %0d expected 3 3 12", aw_cnt, b_cnt, w_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_multi_burst();
    test_stalls();
    test_zero_beats();
    test_reset_mid();
    test_error_resp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
